// File: rtl/mdu_ctrl.sv
// mdu_ctrl: sequencing controller for the E-stage multiply/divide unit.
// Issues datapath start pulses, times the fixed mult/div latency and raises the HI/LO write strobes.
`ifndef MDU_OPS_DEFINED
`define MDU_OPS_DEFINED
`define MDU_none  4'd0
`define MDU_mult  4'd1
`define MDU_multu 4'd2
`define MDU_div   4'd3
`define MDU_divu  4'd4
`define MDU_mfhi  4'd5
`define MDU_mflo  4'd6
`define MDU_mthi  4'd7
`define MDU_mtlo  4'd8
`endif

module mdu_ctrl #(
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10,
   parameter int CNT_W   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req,
   input  logic [3:0] e_op,
   input  logic       d_mdu,
   output logic       stall,
   output logic       busy,
   output logic       dp_start,
   output logic [1:0] dp_kind,
   output logic       res_we,
   output logic       hi_we,
   output logic       lo_we,
   output logic       err
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] op_lat;
   logic [1:0]       kind_q;
   logic [1:0]       kind_nxt;
   logic [1:0]       op_kind;
   logic             err_nxt;
   logic             is_arith;
   logic             is_mdu;
   logic             go;
   logic             idle_ok;

   // Decode the E-stage op; reset gating keeps every output low while reset is held.
   always_comb begin
      is_arith = 1'b0;
      is_mdu   = 1'b1;
      op_kind  = 2'b00;
      op_lat   = CNT_W'(MUL_LAT);
      case (e_op)
         `MDU_mult:  is_arith = 1'b1;
         `MDU_multu: begin
            is_arith = 1'b1;
            op_kind  = 2'b01;
         end
         `MDU_div: begin
            is_arith = 1'b1;
            op_kind  = 2'b10;
            op_lat   = CNT_W'(DIV_LAT);
         end
         `MDU_divu: begin
            is_arith = 1'b1;
            op_kind  = 2'b11;
            op_lat   = CNT_W'(DIV_LAT);
         end
         `MDU_mfhi, `MDU_mflo, `MDU_mthi, `MDU_mtlo: is_mdu = 1'b1;
         default: is_mdu = 1'b0;
      endcase
      idle_ok = (state == IDLE) & ~req & ~reset;
      go      = is_arith & idle_ok;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         kind_q <= 2'b00;
         err    <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         kind_q <= kind_nxt;
         err    <= err_nxt;
      end
   end

   // An in-flight op is already committed, so req never disturbs the countdown.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      kind_nxt  = kind_q;
      err_nxt   = err | ((state == RUN) & is_mdu);
      case (state)
         IDLE: begin
            if (go) begin
               state_nxt = RUN;
               cnt_nxt   = op_lat;
               kind_nxt  = op_kind;
            end
         end
         RUN: begin
            if (cnt == CNT_W'(1)) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // dp_kind shows the decoded kind in the issue cycle so it is valid alongside dp_start.
   always_comb begin
      dp_start = go;
      dp_kind  = go ? op_kind : kind_q;
      busy     = go | (state == RUN);
      stall    = d_mdu & busy;
      res_we   = (state == RUN) & (cnt == CNT_W'(1));
      hi_we    = (e_op == `MDU_mthi) & idle_ok;
      lo_we    = (e_op == `MDU_mtlo) & idle_ok;
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed testbench for mdu_ctrl: inputs change 1ns after the rising edge, outputs are
// checked at the falling edge against hand-computed values.
module tb_mdu_ctrl;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   logic       clk = 1'b0;
   logic       reset;
   logic       req;
   logic [3:0] e_op;
   logic       d_mdu;
   logic       stall;
   logic       busy;
   logic       dp_start;
   logic [1:0] dp_kind;
   logic       res_we;
   logic       hi_we;
   logic       lo_we;
   logic       err;

   int total = 0;
   int bad   = 0;

   mdu_ctrl #(.MUL_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .e_op     (e_op),
      .d_mdu    (d_mdu),
      .stall    (stall),
      .busy     (busy),
      .dp_start (dp_start),
      .dp_kind  (dp_kind),
      .res_we   (res_we),
      .hi_we    (hi_we),
      .lo_we    (lo_we),
      .err      (err)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every output at the falling edge of the current cycle.
   task automatic check_all(input string tag, input logic s, input logic [1:0] k, input logic b,
                            input logic st, input logic r, input logic h, input logic l,
                            input logic e);
      @(negedge clk);
      check({tag, ".dp_start"}, {3'b0, dp_start}, {3'b0, s});
      check({tag, ".dp_kind"},  {2'b0, dp_kind},  {2'b0, k});
      check({tag, ".busy"},     {3'b0, busy},     {3'b0, b});
      check({tag, ".stall"},    {3'b0, stall},    {3'b0, st});
      check({tag, ".res_we"},   {3'b0, res_we},   {3'b0, r});
      check({tag, ".hi_we"},    {3'b0, hi_we},    {3'b0, h});
      check({tag, ".lo_we"},    {3'b0, lo_we},    {3'b0, l});
      check({tag, ".err"},      {3'b0, err},      {3'b0, e});
   endtask

   initial begin
      reset = 1'b1;
      req   = 1'b0;
      e_op  = OP_MULT;
      d_mdu = 1'b1;
      // Reset holds every output low even with a live mult in E.
      check_all("reset", 0, 2'b00, 0, 0, 0, 0, 0, 0);
      tick();
      reset = 1'b0;
      e_op  = OP_NONE;
      d_mdu = 1'b0;
      check_all("idle", 0, 2'b00, 0, 0, 0, 0, 0, 0);

      // mult at cycle 0: busy 0..5, res_we only at 5.
      tick();
      e_op = OP_MULT;
      check_all("mult.c0", 1, 2'b00, 1, 0, 0, 0, 0, 0);
      for (int c = 1; c <= 5; c++) begin
         tick();
         e_op = OP_NONE;
         check_all($sformatf("mult.c%0d", c), 0, 2'b00, 1, 0, (c == 5), 0, 0, 0);
      end
      // Back-to-back issue in the cycle after res_we.
      tick();
      e_op = OP_MULTU;
      check_all("b2b.c0", 1, 2'b01, 1, 0, 0, 0, 0, 0);
      for (int c = 1; c <= 5; c++) begin
         tick();
         e_op = OP_NONE;
         check_all($sformatf("b2b.c%0d", c), 0, 2'b01, 1, 0, (c == 5), 0, 0, 0);
      end

      // divu with d_mdu held: stall 0..10, released at 11.
      tick();
      e_op  = OP_DIVU;
      d_mdu = 1'b1;
      check_all("divu.c0", 1, 2'b11, 1, 1, 0, 0, 0, 0);
      for (int c = 1; c <= 10; c++) begin
         tick();
         e_op = OP_NONE;
         check_all($sformatf("divu.c%0d", c), 0, 2'b11, 1, 1, (c == 10), 0, 0, 0);
      end
      tick();
      check_all("divu.c11", 0, 2'b11, 0, 0, 0, 0, 0, 0);

      // div dropped by req, then mult issues; req at cycle 2 does not disturb it.
      tick();
      d_mdu = 1'b0;
      e_op  = OP_DIV;
      req   = 1'b1;
      check_all("req_div", 0, 2'b11, 0, 0, 0, 0, 0, 0);
      tick();
      e_op = OP_MULT;
      req  = 1'b0;
      check_all("rmul.c0", 1, 2'b00, 1, 0, 0, 0, 0, 0);
      for (int c = 1; c <= 5; c++) begin
         tick();
         e_op = OP_NONE;
         req  = (c == 2);
         check_all($sformatf("rmul.c%0d", c), 0, 2'b00, 1, 0, (c == 5), 0, 0, 0);
      end
      tick();
      req = 1'b0;
      check_all("rmul.c6", 0, 2'b00, 0, 0, 0, 0, 0, 0);

      // mthi / mtlo strobes, then the same pair suppressed by req.
      tick();
      e_op = OP_MTHI;
      check_all("mthi", 0, 2'b00, 0, 0, 0, 1, 0, 0);
      tick();
      e_op = OP_MTLO;
      check_all("mtlo", 0, 2'b00, 0, 0, 0, 0, 1, 0);
      tick();
      e_op = OP_MTHI;
      req  = 1'b1;
      check_all("mthi_req", 0, 2'b00, 0, 0, 0, 0, 0, 0);
      tick();
      e_op = OP_MTLO;
      check_all("mtlo_req", 0, 2'b00, 0, 0, 0, 0, 0, 0);

      // multu injected into a running div sets sticky err; reset aborts the div.
      tick();
      req  = 1'b0;
      e_op = OP_DIV;
      check_all("err.c0", 1, 2'b10, 1, 0, 0, 0, 0, 0);
      for (int c = 1; c <= 2; c++) begin
         tick();
         e_op = OP_NONE;
         check_all($sformatf("err.c%0d", c), 0, 2'b10, 1, 0, 0, 0, 0, 0);
      end
      tick();
      e_op = OP_MULTU;
      check_all("err.c3", 0, 2'b10, 1, 0, 0, 0, 0, 0);
      tick();
      e_op = OP_NONE;
      #1;
      check("err.c4.sticky", {3'b0, err}, 4'd1);
      reset = 1'b1;
      check_all("err.c4.reset", 0, 2'b00, 0, 0, 0, 0, 0, 0);
      tick();
      reset = 1'b0;
      for (int c = 5; c <= 12; c++) begin
         tick();
         check_all($sformatf("abort.c%0d", c), 0, 2'b00, 0, 0, 0, 0, 0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
